// File: rtl/sampler_buffer_drain.sv
// sampler_buffer_drain
//
// Reader side of the lease sampler's reuse-interval buffer. When the buffer
// fills, or when the host asks for an end-of-run flush, this block walks the
// buffer records 0..used-1. It reads the interval, PC, trace and target words
// of each record and streams them as 32-bit words toward the host comm path.
// It then clears the sampler buffer so that sampling can resume.
//
// Ports
//   clock_i         single clock
//   resetn_i        synchronous, active-low reset
//   full_flag_i     sampler buffer full
//   flush_i         one-cycle end-of-run flush request
//   used_i          number of valid records in the buffer
//   ref_interval_i  buffer read data: reuse interval
//   ref_address_i   buffer read data: PC
//   ref_trace_i     buffer read data: 64-bit trace
//   ref_target_i    buffer read data: target
//   add_o           buffer read address (comm[16:4])
//   clear_o         one-cycle buffer clear (comm[23])
//   dump_o          one-cycle table-writeout request (comm[22])
//   data_o          stream word
//   valid_o         stream valid
//   ready_i         stream ready
//   last_o          final word of the drain
//   busy_o          drain in progress
//   done_o          one-cycle pulse when the drain completes
//
// Optional feature: define SAMPLER_DRAIN_CHECKSUM_EN to append one extra word
// after the final record. That word is the XOR of every transferred word, and
// last_o is asserted on it.

module sampler_buffer_drain #(
  parameter int BW_ADDR      = 13,
  parameter int READ_LATENCY = 2,
  parameter int DUMP_CYCLES  = 130
) (
  input  logic               clock_i,
  input  logic               resetn_i,
  input  logic               full_flag_i,
  input  logic               flush_i,
  input  logic [31:0]        used_i,
  input  logic [31:0]        ref_interval_i,
  input  logic [31:0]        ref_address_i,
  input  logic [63:0]        ref_trace_i,
  input  logic [31:0]        ref_target_i,
  output logic [BW_ADDR-1:0] add_o,
  output logic               clear_o,
  output logic               dump_o,
  output logic [31:0]        data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               last_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int DMP_W = (DUMP_CYCLES > 1) ? $clog2(DUMP_CYCLES) : 1;
  localparam logic [31:0]      MAX_REC  = 32'd1 << BW_ADDR;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [DMP_W-1:0] DMP_LAST = DMP_W'(DUMP_CYCLES - 1);
  localparam logic [DMP_W-1:0] DMP_ONE  = DMP_W'(1);
  localparam logic [BW_ADDR:0] REC_ONE  = (BW_ADDR + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_DUMP_WAIT, S_SET_ADDR, S_WAIT_READ, S_SEND, S_CKSUM, S_CLEAR
  } state_t;

  // The state that follows the final record. With the checksum enabled, one
  // extra word is sent before the clear.
`ifdef SAMPLER_DRAIN_CHECKSUM_EN
  localparam state_t END_STATE = S_CKSUM;
`else
  localparam state_t END_STATE = S_CLEAR;
`endif

  state_t           state_q, state_d;
  logic [BW_ADDR:0] nRec_q, nRec_d;
  logic [BW_ADDR:0] recIdx_q, recIdx_d;
  logic [BW_ADDR:0] recNext;
  logic [2:0]       wordIdx_q, wordIdx_d;
  logic [LAT_W-1:0] latCnt_q, latCnt_d;
  logic [DMP_W-1:0] dumpCnt_q, dumpCnt_d;
  logic             flushPend_q, flushPend_d;
  logic             armed_q, armed_d;
  logic [31:0]      recInterval_q, recInterval_d;
  logic [31:0]      recAddress_q, recAddress_d;
  logic [63:0]      recTrace_q, recTrace_d;
  logic [31:0]      recTarget_q, recTarget_d;
  logic [31:0]      sendWord;
`ifdef SAMPLER_DRAIN_CHECKSUM_EN
  logic [31:0]      csum_q, csum_d;
`endif

  // A full buffer holds exactly 2^BW_ADDR records. The record count needs one
  // bit more than the address, so that the top address is read as well.
  function automatic logic [BW_ADDR:0] satUsed(input logic [31:0] used);
    logic [BW_ADDR:0] r;
    if (used > MAX_REC) r = MAX_REC[BW_ADDR:0];
    else                r = used[BW_ADDR:0];
    return r;
  endfunction

  assign recNext = recIdx_q + REC_ONE;

  always_comb begin
    case (wordIdx_q)
      3'd0:    sendWord = recInterval_q;
      3'd1:    sendWord = recAddress_q;
      3'd2:    sendWord = recTrace_q[31:0];
      3'd3:    sendWord = recTrace_q[63:32];
      default: sendWord = recTarget_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    nRec_d        = nRec_q;
    recIdx_d      = recIdx_q;
    wordIdx_d     = wordIdx_q;
    latCnt_d      = latCnt_q;
    dumpCnt_d     = dumpCnt_q;
    flushPend_d   = flushPend_q;
    armed_d       = armed_q;
    recInterval_d = recInterval_q;
    recAddress_d  = recAddress_q;
    recTrace_d    = recTrace_q;
    recTarget_d   = recTarget_q;
`ifdef SAMPLER_DRAIN_CHECKSUM_EN
    csum_d        = csum_q;
`endif

    // Re-trigger guard: full_flag_i must be seen low once after a clear
    // before it can start another drain.
    if (!full_flag_i) armed_d = 1'b1;
    if (flush_i && (state_q != S_IDLE)) flushPend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (full_flag_i && armed_q) begin
          nRec_d      = satUsed(used_i);
          recIdx_d    = '0;
          flushPend_d = flush_i;
`ifdef SAMPLER_DRAIN_CHECKSUM_EN
          csum_d      = '0;
`endif
          state_d     = S_SET_ADDR;
        end else if (flush_i) begin
          dumpCnt_d = '0;
          state_d   = S_DUMP_WAIT;
        end
      end
      S_DUMP_WAIT: begin
        if (dumpCnt_q == DMP_LAST) begin
          nRec_d   = satUsed(used_i);
          recIdx_d = '0;
`ifdef SAMPLER_DRAIN_CHECKSUM_EN
          csum_d   = '0;
`endif
          state_d  = S_SET_ADDR;
        end else begin
          dumpCnt_d = dumpCnt_q + DMP_ONE;
        end
      end
      S_SET_ADDR: begin
        if (nRec_q == '0) begin
          state_d = END_STATE;
        end else begin
          latCnt_d = '0;
          state_d  = S_WAIT_READ;
        end
      end
      S_WAIT_READ: begin
        if (latCnt_q == LAT_LAST) begin
          recInterval_d = ref_interval_i;
          recAddress_d  = ref_address_i;
          recTrace_d    = ref_trace_i;
          recTarget_d   = ref_target_i;
          wordIdx_d     = '0;
          state_d       = S_SEND;
        end else begin
          latCnt_d = latCnt_q + LAT_ONE;
        end
      end
      S_SEND: begin
        if (ready_i) begin
`ifdef SAMPLER_DRAIN_CHECKSUM_EN
          csum_d = csum_q ^ sendWord;
`endif
          if (wordIdx_q == 3'd4) begin
            recIdx_d = recNext;
            state_d  = (recNext == nRec_q) ? END_STATE : S_SET_ADDR;
          end else begin
            wordIdx_d = wordIdx_q + 3'd1;
          end
        end
      end
      S_CKSUM: begin
        if (ready_i) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        armed_d = 1'b0;
        if (flushPend_q || flush_i) begin
          flushPend_d = 1'b0;
          dumpCnt_d   = '0;
          state_d     = S_DUMP_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      state_q       <= S_IDLE;
      nRec_q        <= '0;
      recIdx_q      <= '0;
      wordIdx_q     <= '0;
      latCnt_q      <= '0;
      dumpCnt_q     <= '0;
      flushPend_q   <= 1'b0;
      armed_q       <= 1'b1;
      recInterval_q <= '0;
      recAddress_q  <= '0;
      recTrace_q    <= '0;
      recTarget_q   <= '0;
`ifdef SAMPLER_DRAIN_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      nRec_q        <= nRec_d;
      recIdx_q      <= recIdx_d;
      wordIdx_q     <= wordIdx_d;
      latCnt_q      <= latCnt_d;
      dumpCnt_q     <= dumpCnt_d;
      flushPend_q   <= flushPend_d;
      armed_q       <= armed_d;
      recInterval_q <= recInterval_d;
      recAddress_q  <= recAddress_d;
      recTrace_q    <= recTrace_d;
      recTarget_q   <= recTarget_d;
`ifdef SAMPLER_DRAIN_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  // The read address is held from address setup until the record's last word
  // has left, and it returns to 0 everywhere else.
  assign add_o   = ((state_q == S_SET_ADDR) || (state_q == S_WAIT_READ) ||
                    (state_q == S_SEND)) ? recIdx_q[BW_ADDR-1:0] : '0;
  assign busy_o  = (state_q != S_IDLE);
  assign valid_o = (state_q == S_SEND) || (state_q == S_CKSUM);
  assign clear_o = (state_q == S_CLEAR);
  assign done_o  = (state_q == S_CLEAR);
  assign dump_o  = (state_q == S_DUMP_WAIT) && (dumpCnt_q == '0);

  always_comb begin
    data_o = '0;
    if (state_q == S_SEND) data_o = sendWord;
`ifdef SAMPLER_DRAIN_CHECKSUM_EN
    if (state_q == S_CKSUM) data_o = csum_q;
`endif
  end

`ifdef SAMPLER_DRAIN_CHECKSUM_EN
  assign last_o = (state_q == S_CKSUM);
`else
  assign last_o = (state_q == S_SEND) && (wordIdx_q == 3'd4) && (recNext == nRec_q);
`endif

endmodule

// File: tb/tb_sampler_buffer_drain.sv
// Self-checking bench for sampler_buffer_drain.
// A two-cycle-latency buffer model feeds the ref_* inputs. Every expected
// stream word is queued when a drain is triggered, and it is compared as the
// DUT transfers the word.

module tb_sampler_buffer_drain;

  logic        clock_i = 1'b0;
  logic        resetn_i;
  logic        full_flag_i;
  logic        flush_i;
  logic [31:0] used_i;
  logic [31:0] ref_interval_i;
  logic [31:0] ref_address_i;
  logic [63:0] ref_trace_i;
  logic [31:0] ref_target_i;
  logic [12:0] add_o;
  logic        clear_o;
  logic        dump_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        last_o;
  logic        busy_o;
  logic        done_o;

  sampler_buffer_drain dut (
    .clock_i(clock_i), .resetn_i(resetn_i), .full_flag_i(full_flag_i),
    .flush_i(flush_i), .used_i(used_i), .ref_interval_i(ref_interval_i),
    .ref_address_i(ref_address_i), .ref_trace_i(ref_trace_i),
    .ref_target_i(ref_target_i), .add_o(add_o), .clear_o(clear_o),
    .dump_o(dump_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clock_i = ~clock_i;

  // Buffer model: the data for add_o appears two clocks after the address.
  logic [12:0] p1Addr = '0;
  logic [12:0] p2Addr = '0;
  logic [31:0] baseInt, baseAdr, baseTgt;
  logic [63:0] baseTrace;

  always @(posedge clock_i) begin
    p1Addr <= add_o;
    p2Addr <= p1Addr;
  end

  always_comb begin
    ref_interval_i = baseInt + 32'(p2Addr);
    ref_address_i  = baseAdr + (32'(p2Addr) << 2);
    ref_trace_i    = baseTrace + (64'(p2Addr) << 36) + 64'(p2Addr);
    ref_target_i   = baseTgt ^ (32'(p2Addr) << 8);
  end

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        chkAddr;
    logic [12:0] addr;
  } exp_t;

  typedef struct {
    int   used;
    logic viaFlush;
    logic toggle;
    int   words;
    int   clears;
    int   dumps;
    int   dones;
    int   lasts;
  } vec_t;

  exp_t expQ[$];
  vec_t vecs[4];

  int nVec = 0;
  int nMis = 0;
  int cyc = 0;
  int phase = 0;
  int wordCnt = 0, lastCnt = 0, clearCnt = 0, dumpCnt = 0, doneCnt = 0;
  int clearCyc = 0, dumpCyc = 0;
  int sWords, sLasts, sClears, sDumps, sDones;
  int ckExtra;
  logic        readyToggle = 1'b0;
  logic [3:0]  readyPat = 4'b1001;
  logic        prevValid = 1'b0, prevReady = 1'b0, prevResetn = 1'b0, prevLast = 1'b0;
  logic [31:0] prevData = '0;
  logic [12:0] lastDataAddr = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    nVec++;
    if (got !== want) begin
      nMis++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic sampleOutputs();
    exp_t e;
    if (valid_o && ready_i) begin
      wordCnt++;
      if (last_o) lastCnt++;
      if (expQ.size() == 0) begin
        nVec++;
        nMis++;
        $display("[TB] FAIL unexpected-word: got 0x%0h, want no word", data_o);
      end else begin
        e = expQ.pop_front();
        check("word-data", 64'(data_o), 64'(e.data));
        check("word-last", 64'(last_o), 64'(e.last));
        if (e.chkAddr) begin
          check("word-addr", 64'(add_o), 64'(e.addr));
          lastDataAddr = add_o;
        end
      end
    end
    if (prevValid && !prevReady && prevResetn) begin
      check("stall-valid", 64'(valid_o), 64'(1));
      check("stall-data", 64'(data_o), 64'(prevData));
      check("stall-last", 64'(last_o), 64'(prevLast));
    end
    if (clear_o) begin clearCnt++; clearCyc = cyc; end
    if (dump_o) begin dumpCnt++; dumpCyc = cyc; end
    if (done_o) doneCnt++;
    prevValid  = valid_o;
    prevReady  = ready_i;
    prevResetn = resetn_i;
    prevData   = data_o;
    prevLast   = last_o;
  endtask

  task automatic tick();
    @(negedge clock_i);
    sampleOutputs();
    @(posedge clock_i);
    #1;
    cyc++;
    phase++;
    ready_i = readyToggle ? readyPat[phase % 4] : 1'b1;
  endtask

  task automatic setBases(input int idx);
    baseInt   = 32'h10 + (32'(idx) << 24);
    baseAdr   = 32'h400 + (32'(idx) << 20);
    baseTrace = 64'h1_0000_0002 + (64'(idx) << 40);
    baseTgt   = 32'hABC ^ (32'(idx) << 24);
  endtask

  task automatic pushDrain(input int n);
    logic [31:0] cs;
    logic [31:0] a;
    logic [31:0] w[5];
    logic [63:0] tr;
    exp_t e;
    cs = '0;
    for (int r = 0; r < n; r++) begin
      a    = 32'(r);
      tr   = baseTrace + (64'(a) << 36) + 64'(a);
      w[0] = baseInt + a;
      w[1] = baseAdr + (a << 2);
      w[2] = tr[31:0];
      w[3] = tr[63:32];
      w[4] = baseTgt ^ (a << 8);
      for (int k = 0; k < 5; k++) begin
        e.data    = w[k];
`ifdef SAMPLER_DRAIN_CHECKSUM_EN
        e.last    = 1'b0;
`else
        e.last    = (r == n - 1) && (k == 4);
`endif
        e.chkAddr = 1'b1;
        e.addr    = 13'(r);
        expQ.push_back(e);
        cs = cs ^ w[k];
      end
    end
`ifdef SAMPLER_DRAIN_CHECKSUM_EN
    e.data = cs; e.last = 1'b1; e.chkAddr = 1'b0; e.addr = '0;
    expQ.push_back(e);
`endif
  endtask

  task automatic snap();
    sWords = wordCnt; sLasts = lastCnt; sClears = clearCnt;
    sDumps = dumpCnt; sDones = doneCnt;
  endtask

  task automatic waitDone(input int budget, input string name);
    int start;
    int k;
    start = doneCnt;
    k = 0;
    while (doneCnt == start && k < budget) begin
      tick();
      k++;
    end
    nVec++;
    if (doneCnt == start) begin
      nMis++;
      $display("[TB] FAIL %s: done_o not seen within %0d cycles, want a pulse", name, budget);
    end
  endtask

  task automatic checkAllZero(input string name);
    check({name, "-busy"},  64'(busy_o),  64'(0));
    check({name, "-valid"}, 64'(valid_o), 64'(0));
    check({name, "-data"},  64'(data_o),  64'(0));
    check({name, "-last"},  64'(last_o),  64'(0));
    check({name, "-add"},   64'(add_o),   64'(0));
    check({name, "-clear"}, 64'(clear_o), 64'(0));
    check({name, "-dump"},  64'(dump_o),  64'(0));
    check({name, "-done"},  64'(done_o),  64'(0));
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    setBases(idx);
    used_i      = 32'(v.used);
    readyToggle = v.toggle;
    phase       = 0;
    snap();
    pushDrain(v.used);
    if (v.viaFlush) flush_i = 1'b1;
    else            full_flag_i = 1'b1;
    tick();
    flush_i     = 1'b0;
    full_flag_i = 1'b0;
    waitDone(3000, $sformatf("vec%0d-done", idx));
    tick();
    tick();
    readyToggle = 1'b0;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    int expLasts;
`ifdef SAMPLER_DRAIN_CHECKSUM_EN
    expLasts = 1;
`else
    expLasts = v.lasts;
`endif
    check($sformatf("vec%0d-words", idx),  64'(wordCnt - sWords),   64'(v.words + ckExtra));
    check($sformatf("vec%0d-lasts", idx),  64'(lastCnt - sLasts),   64'(expLasts));
    check($sformatf("vec%0d-clears", idx), 64'(clearCnt - sClears), 64'(v.clears));
    check($sformatf("vec%0d-dumps", idx),  64'(dumpCnt - sDumps),   64'(v.dumps));
    check($sformatf("vec%0d-dones", idx),  64'(doneCnt - sDones),   64'(v.dones));
    check($sformatf("vec%0d-pending", idx), 64'(expQ.size()),       64'(0));
    check($sformatf("vec%0d-idle", idx),   64'(busy_o),             64'(0));
  endtask

  initial begin
    int firstClear;
    int k;
`ifdef SAMPLER_DRAIN_CHECKSUM_EN
    ckExtra = 1;
`else
    ckExtra = 0;
`endif
    resetn_i    = 1'b0;
    full_flag_i = 1'b0;
    flush_i     = 1'b0;
    used_i      = '0;
    ready_i     = 1'b1;
    setBases(0);

    //            used  flush  toggle words clears dumps dones lasts
    vecs[0] = '{1,    1'b0,  1'b0,  5,    1,     0,    1,    1};
    vecs[1] = '{3,    1'b0,  1'b1,  15,   1,     0,    1,    1};
    vecs[2] = '{0,    1'b1,  1'b0,  0,    1,     1,    1,    0};
    vecs[3] = '{4,    1'b1,  1'b1,  20,   1,     1,    1,    1};

    $display("[TB] reset");
    repeat (3) tick();
    checkAllZero("reset");
    resetn_i = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 4; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(i, vecs[i]);
      checkOutput(i, vecs[i]);
    end

    $display("[TB] simultaneous full and flush");
    setBases(5);
    used_i = 32'd2;
    snap();
    pushDrain(2);
    pushDrain(2);
    full_flag_i = 1'b1;
    flush_i     = 1'b1;
    tick();
    full_flag_i = 1'b0;
    flush_i     = 1'b0;
    waitDone(200, "simul-first-done");
    firstClear = clearCyc;
    check("simul-first-words",  64'(wordCnt - sWords),   64'(10 + ckExtra));
    check("simul-first-clears", 64'(clearCnt - sClears), 64'(1));
    check("simul-first-dumps",  64'(dumpCnt - sDumps),   64'(0));
    waitDone(600, "simul-second-done");
    tick();
    tick();
    check("simul-words",   64'(wordCnt - sWords),   64'(20 + 2 * ckExtra));
    check("simul-clears",  64'(clearCnt - sClears), 64'(2));
    check("simul-dumps",   64'(dumpCnt - sDumps),   64'(1));
    check("simul-order",   64'((dumpCyc > firstClear) && (clearCyc > dumpCyc)), 64'(1));
    check("simul-pending", 64'(expQ.size()), 64'(0));

    $display("[TB] re-trigger guard");
    setBases(6);
    used_i = 32'd1;
    snap();
    pushDrain(1);
    full_flag_i = 1'b1;
    tick();
    waitDone(100, "guard-done");
    repeat (4) tick();
    check("guard-held-idle", 64'(busy_o), 64'(0));
    check("guard-clears",    64'(clearCnt - sClears), 64'(1));
    full_flag_i = 1'b0;
    tick();
    tick();
    check("guard-pending", 64'(expQ.size()), 64'(0));

    $display("[TB] reset during send");
    setBases(7);
    used_i = 32'd2;
    snap();
    pushDrain(2);
    full_flag_i = 1'b1;
    tick();
    full_flag_i = 1'b0;
    k = 0;
    while ((wordCnt - sWords) < 2 && k < 50) begin
      tick();
      k++;
    end
    check("rst-reached-word2", 64'(wordCnt - sWords), 64'(2));
    resetn_i = 1'b0;
    ready_i  = 1'b0;
    expQ.delete();
    tick();
    checkAllZero("rst-mid");
    tick();
    tick();
    resetn_i = 1'b1;
    repeat (3) tick();
    check("rst-no-clear", 64'(clearCnt - sClears), 64'(0));
    check("rst-no-done",  64'(doneCnt - sDones),   64'(0));
    snap();
    pushDrain(2);
    full_flag_i = 1'b1;
    tick();
    full_flag_i = 1'b0;
    waitDone(200, "rst-restart-done");
    tick();
    check("rst-restart-words", 64'(wordCnt - sWords), 64'(10 + ckExtra));
    check("rst-restart-pending", 64'(expQ.size()), 64'(0));

    $display("[TB] full buffer");
    setBases(8);
    used_i = 32'd8192;
    snap();
    pushDrain(8192);
    full_flag_i = 1'b1;
    tick();
    full_flag_i = 1'b0;
    waitDone(70000, "full-done");
    tick();
    tick();
    check("full-words",    64'(wordCnt - sWords),   64'(40960 + ckExtra));
    check("full-clears",   64'(clearCnt - sClears), 64'(1));
    check("full-top-addr", 64'(lastDataAddr),       64'(13'h1FFF));
    check("full-pending",  64'(expQ.size()),        64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/sampler_buffer_drain.md
Name: sampler_buffer_drain

Overview:
- Reader side of the lease sampler's reuse-interval buffer.
- On a buffer-full condition, or on an end-of-run flush request, it walks buffer addresses 0..used-1 and reads the interval, PC, trace and target words for each record.
- It serialises each record into 32-bit words on a valid/ready stream toward the host comm path, then clears the sampler buffer so sampling resumes.
- Sits between the sampler's read port and the host transfer logic; it owns the sampler's comm address/clear/dump fields.

Parameters:
- BW_ADDR, 13, width of buffer address (matches the 8192-entry buffer).
- READ_LATENCY, 2, cycles from add_o change to valid ref_* data.
- DUMP_CYCLES, 130, cycles to wait after dump_o for table writeout (N_SAMPLER+2).

Ports:
- clock_i  in  1  single clock.
- resetn_i  in  1  synchronous, active-low reset.
- full_flag_i  in  1  sampler buffer full.
- flush_i  in  1  single-cycle pulse; end of run, logging disabled.
- used_i  in  32  number of valid records in the buffer.
- ref_interval_i  in  32  buffer read data.
- ref_address_i  in  32  buffer read data.
- ref_trace_i  in  64  buffer read data.
- ref_target_i  in  32  buffer read data.
- add_o  out  BW_ADDR  buffer read address; maps to comm[16:4].
- clear_o  out  1  one-cycle buffer clear; maps to comm[23].
- dump_o  out  1  one-cycle table-writeout request; maps to comm[22].
- data_o  out  32  stream word.
- valid_o  out  1  stream valid.
- ready_i  in  1  stream ready.
- last_o  out  1  final word of the drain.
- busy_o  out  1  drain in progress.
- done_o  out  1  one-cycle pulse when the drain completes.

Behaviour:
- Reset (resetn_i low at a clock edge): state IDLE.
  - All outputs 0; internal counters 0.
  - Reset mid-drain aborts without issuing clear_o.
- IDLE:
  - full_flag_i high -> latch used_i[BW_ADDR:0], saturated at 2^BW_ADDR, into n_rec; go to SET_ADDR.
  - Else flush_i -> pulse dump_o, go to DUMP_WAIT.
  - If both are high in the same cycle, full_flag_i wins; the flush is remembered and serviced after the clear.
- DUMP_WAIT:
  - Count DUMP_CYCLES.
  - Then latch used_i into n_rec, go to SET_ADDR.
- busy_o is high in every state except IDLE.
- SET_ADDR:
  - If n_rec==0, go to CLEAR.
  - Else drive add_o=rec_idx, go to WAIT_READ.
- WAIT_READ:
  - Hold add_o for READ_LATENCY cycles.
  - Capture all four ref_* inputs into a record register, go to SEND.
- SEND: 5 words in order, word_idx 0..4:
  - 0: interval
  - 1: address
  - 2: trace[31:0]
  - 3: trace[63:32]
  - 4: target
- Stream handshake:
  - A word transfers when valid_o && ready_i.
  - data_o and last_o are stable while valid_o is high and ready_i is low.
  - valid_o never drops until the word transfers.
  - Back-to-back words within a record: one per cycle when ready_i stays high.
  - After word 4 transfers: rec_idx++; if rec_idx==n_rec go to CLEAR, else go to SET_ADDR.
- Throughput: minimum 1 + READ_LATENCY + 5 cycles per record.
- last_o is high only on word 4 of the final record (or on the checksum word when the optional feature is enabled).
- CLEAR:
  - Pulse clear_o for one cycle; add_o returns to 0.
  - Pulse done_o, go to IDLE.
  - If a flush is pending, go to DUMP_WAIT instead, pulsing dump_o.
- Both dump_o and clear_o are one-cycle pulses.
- Re-trigger guard: a new drain does not start until full_flag_i has been observed low for at least one cycle since the last clear_o.
- rec_idx wraps never; it ranges 0..n_rec-1. The n_rec==2^BW_ADDR case reads all addresses, including the top one.
- flush_i arriving while busy is latched (one deep) and serviced after the current drain completes.

Optional Feature:
- Macro: SAMPLER_DRAIN_CHECKSUM_EN.
- Defined:
  - A running 32-bit XOR of every transferred data word is kept.
  - After the final record, one extra word {checksum} is sent, and last_o is asserted on it.
  - An empty drain (n_rec==0) sends only the checksum word, value 0.
- Undefined:
  - No extra word is sent.
  - An empty drain sends nothing; last_o never asserts for it, and done_o still pulses.

Test Plan:
- Single record, ready_i always 1: used_i=1, full_flag_i pulse, ref_interval_i=0x10, ref_address_i=0x400, ref_trace_i=0x1_00000002, ref_target_i=0xABC.
  - Required: data_o sequence 0x10, 0x400, 0x2, 0x1, 0xABC; last_o on the 5th word; then clear_o and done_o.
- Backpressure: used_i=3; ready_i toggles 1,0,0,1 repeating.
  - Required: 15 words; no word is dropped or duplicated; data_o is stable while stalled; add_o visits 0, 1, 2.
- Empty flush: flush_i with used_i=0 after DUMP_CYCLES.
  - Required: dump_o 1 cycle; no stream words (checksum word 0 if the macro is enabled); clear_o and done_o.
- Simultaneous trigger: full_flag_i and flush_i in the same cycle, used_i=2.
  - Required: 10 words, then clear_o, then dump_o, then a second drain.
- Full buffer: used_i=8192.
  - Required: last record read at add_o=0x1FFF; 40960 words; exactly one clear_o.
- Reset mid-SEND: resetn_i low during word 2 of record 0.
  - Required: next cycle all outputs 0; no clear_o; a new full_flag_i restarts the drain at add_o=0.
